// File: rtl/axi_frame_rd_addr_gen.sv
// axi_frame_rd_addr_gen: splits frame read requests into AXI INCR bursts on the AR channel.
// Define AXI_4KB_BOUNDARY_SPLIT_EN to also limit each burst so it never crosses a 4 KB page.
module axi_frame_rd_addr_gen #(
    parameter int axi_rwaddr_outstanding = 2,
    parameter int axi_data_width         = 64,
    parameter int max_burst_len          = 16,
    parameter int simulation_delay       = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    output logic        frame_ready,
    input  logic [31:0] frame_base_addr,
    input  logic [23:0] frame_beats,
    output logic        frame_addr_done,
    output logic [31:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    output logic        trans_fifo_wen,
    input  logic        trans_fifo_full,
    output logic        trans_fifo_din
);
    localparam int bsh = $clog2(axi_data_width / 8);

    if (axi_rwaddr_outstanding < 1 || axi_rwaddr_outstanding > 16 ||
        (axi_rwaddr_outstanding & (axi_rwaddr_outstanding - 1)) != 0 ||
        (axi_data_width != 32 && axi_data_width != 64 && axi_data_width != 128) ||
        max_burst_len < 1 || max_burst_len > 256 || simulation_delay < 0) begin : g_bad_param
        $error("axi_frame_rd_addr_gen: unsupported parameter set");
    end

    typedef enum logic [1:0] {IDLE, CALC, ISSUE} state_t;
    state_t state, state_nxt;

    logic [31:0] addr;
    logic [23:0] rem;
    logic [23:0] cap;
    logic [23:0] len;
    logic        last;

`ifdef AXI_4KB_BOUNDARY_SPLIT_EN
    logic [12:0] room;
    assign room = 13'h1000 - {1'b0, addr[11:0]};
    assign cap  = 24'(room >> bsh) < 24'(max_burst_len) ? 24'(room >> bsh) : 24'(max_burst_len);
`else
    assign cap = 24'(max_burst_len);
`endif
    assign len = rem < cap ? rem : cap;

    assign frame_ready    = state == IDLE;
    assign m_axi_arvalid  = state == ISSUE;
    assign m_axi_arsize   = 3'(bsh);
    assign m_axi_arburst  = 2'b01;
    assign trans_fifo_wen = m_axi_arvalid & m_axi_arready;
    assign trans_fifo_din = last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_start && frame_beats != 24'd0) state_nxt = CALC;
            CALC:    if (!trans_fifo_full) state_nxt = ISSUE;
            ISSUE:   if (m_axi_arready) state_nxt = last ? IDLE : CALC;
            default: state_nxt = IDLE;
        endcase
    end

    // CALC only leaves when a FIFO slot is free; only this block fills the FIFO, so the slot holds until the handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr            <= '0;
            rem             <= '0;
            m_axi_araddr    <= '0;
            m_axi_arlen     <= '0;
            last            <= 1'b0;
            frame_addr_done <= 1'b0;
        end else begin
            frame_addr_done <= (frame_ready && frame_start && frame_beats == 24'd0) ||
                               (trans_fifo_wen && last);
            if (frame_ready && frame_start) begin
                addr <= frame_base_addr;
                rem  <= frame_beats;
            end
            if (state == CALC && !trans_fifo_full) begin
                m_axi_araddr <= addr;
                m_axi_arlen  <= 8'(len - 24'd1);
                last         <= rem == len;
            end
            if (trans_fifo_wen) begin
                addr <= addr + ((32'(m_axi_arlen) + 32'd1) << bsh);
                rem  <= rem - 24'(m_axi_arlen) - 24'd1;
            end
        end
    end
endmodule

// File: tb/tb_axi_frame_rd_addr_gen.sv
// tb_axi_frame_rd_addr_gen: directed checks of burst splitting, outstanding limit, back-pressure and reset.
module tb_axi_frame_rd_addr_gen;
    localparam int depth = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        frame_ready;
    logic [31:0] frame_base_addr = '0;
    logic [23:0] frame_beats = '0;
    logic        frame_addr_done;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b1;
    logic        trans_fifo_wen;
    logic        trans_fifo_full;
    logic        trans_fifo_din;

    logic auto_pop = 1'b1;
    logic pop_one = 1'b0;
    logic pop;
    int   cnt;
    int   viol;
    int   n_cmp = 0;
    int   n_bad = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  l;
        logic        d;
    } rec_t;
    rec_t q[$];

    axi_frame_rd_addr_gen dut (
        .clk(clk), .rst_n(rst_n),
        .frame_start(frame_start), .frame_ready(frame_ready),
        .frame_base_addr(frame_base_addr), .frame_beats(frame_beats),
        .frame_addr_done(frame_addr_done),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .trans_fifo_wen(trans_fifo_wen), .trans_fifo_full(trans_fifo_full),
        .trans_fifo_din(trans_fifo_din)
    );

    always #5 clk = ~clk;

    assign trans_fifo_full = cnt >= depth;
    assign pop = (auto_pop | pop_one) & (cnt != 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= 0;
        end else begin
            cnt <= cnt + int'(trans_fifo_wen) - int'(pop);
            if (trans_fifo_wen && trans_fifo_full) viol <= viol + 1;
            if (trans_fifo_wen) q.push_back('{m_axi_araddr, m_axi_arlen, trans_fifo_din});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rec(input int i, input logic [31:0] a, input logic [7:0] l, input logic d);
        rec_t r;
        r = i < q.size() ? q[i] : '0;
        check($sformatf("rec%0d_addr", i), r.a, a);
        check($sformatf("rec%0d_len", i), 32'(r.l), 32'(l));
        check($sformatf("rec%0d_din", i), 32'(r.d), 32'(d));
    endtask

    // drives one request; returns at the negedge of the cycle after the accepting edge
    task automatic send(input logic [31:0] base, input logic [23:0] beats);
        @(negedge clk);
        frame_start = 1'b1;
        frame_base_addr = base;
        frame_beats = beats;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 60 && !frame_addr_done; i++) @(negedge clk);
        check(tag, 32'(frame_addr_done), 32'd1);
    endtask

    task automatic wait_arvalid(input string tag);
        for (int i = 0; i < 20 && !m_axi_arvalid; i++) @(negedge clk);
        check(tag, 32'(m_axi_arvalid), 32'd1);
    endtask

    initial begin
        viol = 0;
        #12;
        check("rst_ready", 32'(frame_ready), 32'd1);
        check("rst_arvalid", 32'(m_axi_arvalid), 32'd0);
        check("rst_wen", 32'(trans_fifo_wen), 32'd0);
        check("rst_done", 32'(frame_addr_done), 32'd0);
        check("rst_araddr", m_axi_araddr, 32'd0);
        check("rst_arlen", 32'(m_axi_arlen), 32'd0);
        check("rst_din", 32'(trans_fifo_din), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // single burst with exact latency
        q.delete();
        send(32'h1000, 24'd10);
        check("t1_calc_arvalid", 32'(m_axi_arvalid), 32'd0);
        @(negedge clk);
        check("t1_arvalid", 32'(m_axi_arvalid), 32'd1);
        check("t1_araddr", m_axi_araddr, 32'h1000);
        check("t1_arlen", 32'(m_axi_arlen), 32'd9);
        check("t1_arsize", 32'(m_axi_arsize), 32'd3);
        check("t1_arburst", 32'(m_axi_arburst), 32'd1);
        check("t1_wen", 32'(trans_fifo_wen), 32'd1);
        check("t1_din", 32'(trans_fifo_din), 32'd1);
        @(negedge clk);
        check("t1_done", 32'(frame_addr_done), 32'd1);
        check("t1_ready", 32'(frame_ready), 32'd1);
        check("t1_arvalid_low", 32'(m_axi_arvalid), 32'd0);
        check("t1_nrec", q.size(), 32'd1);

        // zero-beat frame: done pulse, no AR
        q.delete();
        send(32'h5000, 24'd0);
        check("t0_done", 32'(frame_addr_done), 32'd1);
        check("t0_ready", 32'(frame_ready), 32'd1);
        repeat (3) @(negedge clk);
        check("t0_nrec", q.size(), 32'd0);

        // multi-burst
        q.delete();
        send(32'h0, 24'd40);
        wait_done("t2_done");
        check("t2_nrec", q.size(), 32'd3);
        check_rec(0, 32'h0, 8'd15, 1'b0);
        check_rec(1, 32'h80, 8'd15, 1'b0);
        check_rec(2, 32'h100, 8'd7, 1'b1);
        repeat (3) @(negedge clk);

        // outstanding limit with depth 2
        q.delete();
        auto_pop = 1'b0;
        send(32'h0, 24'd40);
        repeat (12) @(negedge clk);
        check("t3_nrec", q.size(), 32'd2);
        check("t3_stall_arvalid", 32'(m_axi_arvalid), 32'd0);
        check("t3_full", 32'(trans_fifo_full), 32'd1);
        check("t3_ready", 32'(frame_ready), 32'd0);
        pop_one = 1'b1;
        @(negedge clk);
        pop_one = 1'b0;
        check("t3_pop_plus1", 32'(m_axi_arvalid), 32'd0);
        @(negedge clk);
        check("t3_pop_plus2", 32'(m_axi_arvalid), 32'd1);
        check("t3_araddr", m_axi_araddr, 32'h100);
        check("t3_arlen", 32'(m_axi_arlen), 32'd7);
        @(negedge clk);
        check("t3_done", 32'(frame_addr_done), 32'd1);
        auto_pop = 1'b1;
        repeat (4) @(negedge clk);

        // back-pressure
        q.delete();
        m_axi_arready = 1'b0;
        send(32'h2000, 24'd4);
        wait_arvalid("t4_arvalid_up");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_valid", 32'(m_axi_arvalid), 32'd1);
            check("t4_hold_addr", m_axi_araddr, 32'h2000);
            check("t4_hold_len", 32'(m_axi_arlen), 32'd3);
            check("t4_hold_wen", 32'(trans_fifo_wen), 32'd0);
        end
        m_axi_arready = 1'b1;
        #1;
        check("t4_wen", 32'(trans_fifo_wen), 32'd1);
        wait_done("t4_done");
        check("t4_nrec", q.size(), 32'd1);
        repeat (3) @(negedge clk);

        // 4 KB boundary
        q.delete();
        send(32'hFC0, 24'd16);
        wait_done("t5_done");
`ifdef AXI_4KB_BOUNDARY_SPLIT_EN
        check("t5_nrec", q.size(), 32'd2);
        check_rec(0, 32'hFC0, 8'd7, 1'b0);
        check_rec(1, 32'h1000, 8'd7, 1'b1);
`else
        check("t5_nrec", q.size(), 32'd1);
        check_rec(0, 32'hFC0, 8'd15, 1'b1);
`endif
        repeat (3) @(negedge clk);

        // reset while an AR is pending
        m_axi_arready = 1'b0;
        send(32'h3000, 24'd8);
        wait_arvalid("t6_arvalid_up");
        rst_n = 1'b0;
        #1;
        check("t6_rst_arvalid", 32'(m_axi_arvalid), 32'd0);
        check("t6_rst_ready", 32'(frame_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        m_axi_arready = 1'b1;
        q.delete();
        send(32'h40, 24'd1);
        wait_done("t6_done");
        check("t6_nrec", q.size(), 32'd1);
        check_rec(0, 32'h40, 8'd0, 1'b1);

        check("wen_while_full", viol, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
